incident_frame_tx: RTL and testbench

Downstream stage of the channel signal-detection block: it captures every incident record that block announces (a one-cycle `incident_inform` strobe with four status bytes), queues records in a small FIFO, and serializes each into a fixed 7-byte frame. The frame carries a header, a sequence number, the four bytes and a checksum. Bytes are handed over a valid/ready byte stream to the UART/SPI link toward the K64 controller. Overflow is reported rather than stalling the detectors, which cannot be back-pressured.

---
 rtl/incident_pkg.sv | 35 +++
 rtl/incident_fifo.sv | 49 ++++
 rtl/incident_frame_tx.sv | 144 ++++++++++++++
 tb/tb_incident_frame_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/incident_pkg.sv
// Shared types and constants for the incident frame transmitter.
package incident_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN   = 7;
  localparam int         IDX_W       = 3;

  // Byte positions inside a frame
  localparam logic [IDX_W-1:0] IDX_HDR = 3'd0;
  localparam logic [IDX_W-1:0] IDX_SEQ = 3'd1;
  localparam logic [IDX_W-1:0] IDX_B0  = 3'd2;
  localparam logic [IDX_W-1:0] IDX_B1  = 3'd3;
  localparam logic [IDX_W-1:0] IDX_B2  = 3'd4;
  localparam logic [IDX_W-1:0] IDX_B3  = 3'd5;
  localparam logic [IDX_W-1:0] IDX_CHK = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // b0 occupies the most significant byte of the packed record
  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
  } record_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] seq, input record_t rec);
    return seq + rec.b0 + rec.b1 + rec.b2 + rec.b3;
  endfunction

endpackage

// File: rtl/incident_fifo.sv
// Synchronous record FIFO; an extra pointer bit separates full from empty.
module incident_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; read side is show-ahead so a same-cycle overwrite of the head is safe
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/incident_frame_tx.sv
// Captures incident records, queues them and serializes each as a 7-byte frame.
//
// state | meaning
// IDLE  | waiting for a queued record; pops it into the shadow register
// LOAD  | computes checksum, rewinds byte index
// SEND  | presents frame bytes on the valid/ready stream
module incident_frame_tx
  import incident_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  HDR_BYTE   = HDR_DEFAULT,
  localparam int         CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          incident_inform,
  input  logic [7:0]    incident_b0,
  input  logic [7:0]    incident_b1,
  input  logic [7:0]    incident_b2,
  input  logic [7:0]    incident_b3,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  output logic [7:0]    drop_count,
  input  logic          overflow_clr
);

  state_t         state;
  state_t         state_next;
  record_t        shadow;
  record_t        fifo_rdata;
  logic [7:0]     seq;
  logic [7:0]     chk;
  logic [IDX_W-1:0] idx;
  logic           fifo_pop;
  logic           fifo_push;
  logic           fifo_full;
  logic           fifo_empty;
  logic           drop;
  logic           accept;
  logic           last_accept;

  // A drop happens only if the FIFO is full and the FSM is not freeing a slot this cycle
  assign drop      = incident_inform && fifo_full && !fifo_pop;
  assign fifo_push = incident_inform && !drop;

  incident_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({incident_b0, incident_b1, incident_b2, incident_b3}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_valid    = (state == ST_SEND);
  assign accept      = tx_valid && tx_ready;
  assign last_accept = accept && (idx == IDX_CHK);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and pop control
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: state_next = ST_SEND;
      ST_SEND: begin
        if (last_accept) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame datapath: shadow record, checksum, byte index and sequence number
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      chk    <= '0;
      idx    <= IDX_HDR;
      seq    <= '0;
    end else begin
      if (fifo_pop) shadow <= fifo_rdata;
      if (state == ST_LOAD) begin
        chk <= frame_chk(seq, shadow);
        idx <= IDX_HDR;
      end else if (accept) begin
        if (idx == IDX_CHK) seq <= seq + 8'd1;
        else                idx <= idx + 3'd1;
      end
    end
  end

  // Byte mux; stays constant while stalled since idx only moves on acceptance
  always_comb begin
    tx_data = 8'h00;
    if (tx_valid) begin
      case (idx)
        IDX_HDR: tx_data = HDR_BYTE;
        IDX_SEQ: tx_data = seq;
        IDX_B0:  tx_data = shadow.b0;
        IDX_B1:  tx_data = shadow.b1;
        IDX_B2:  tx_data = shadow.b2;
        IDX_B3:  tx_data = shadow.b3;
        IDX_CHK: tx_data = chk;
        default: tx_data = 8'h00;
      endcase
    end
  end

  // Overflow flag and saturating drop counter; a drop outranks a coincident clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clr)              drop_count <= 8'd1;
      else if (drop_count != 8'hFF)  drop_count <= drop_count + 8'd1;
    end else if (overflow_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_incident_frame_tx.sv
// Scoreboard bench for incident_frame_tx.
module tb_incident_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       incident_inform;
  logic [7:0] incident_b0, incident_b1, incident_b2, incident_b3;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] drop_count;
  logic       overflow_clr;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_seq;

  always #5 clk = ~clk;

  incident_frame_tx #(
    .FIFO_DEPTH (8),
    .HDR_BYTE   (8'hA5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .incident_inform (incident_inform),
    .incident_b0     (incident_b0),
    .incident_b1     (incident_b1),
    .incident_b2     (incident_b2),
    .incident_b3     (incident_b3),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .drop_count      (drop_count),
    .overflow_clr    (overflow_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    exp_q.delete();
    model_seq = 8'h00;
    rst = 1'b0;
  endtask

  task automatic send_strobe(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    incident_inform = 1'b1;
    incident_b0 = b0; incident_b1 = b1; incident_b2 = b2; incident_b3 = b3;
    tick();
    incident_inform = 1'b0;
  endtask

  task automatic push_fixed(input logic [7:0] seq, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] chk);
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    exp_q.push_back(chk);
  endtask

  task automatic push_model(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] c;
    c = model_seq + b0 + b1 + b2 + b3;
    push_fixed(model_seq, b0, b1, b2, b3, c);
    model_seq = model_seq + 8'd1;
  endtask

  task automatic drain(input bit rand_ready, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !tx_valid) begin
        done = 1'b1;
        break;
      end
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending bytes expected=0", exp_q.size());
    end
  endtask

  // Monitor: values are stable between posedge+1 and the next posedge, so a
  // negedge sample shows exactly what the coming edge will accept.
  initial begin
    bit         stall_pending;
    bit         prev_rst;
    logic [7:0] stall_data;
    logic [7:0] e;
    stall_pending = 1'b0;
    prev_rst      = 1'b1;
    stall_data    = 8'h00;
    forever begin
      @(negedge clk);
      if (stall_pending && !prev_rst) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
          errors++;
          $display("FAIL stall_stable actual=%b/%0h expected=1/%0h", tx_valid, tx_data, stall_data);
        end
      end
      stall_pending = (tx_valid === 1'b1) && (tx_ready === 1'b0);
      stall_data    = tx_data;
      prev_rst      = rst;
      if (tx_valid === 1'b1 && tx_ready === 1'b1 && !rst) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte actual=%0h expected=none", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL frame_byte actual=%0h expected=%0h", tx_data, e);
          end
        end
      end
    end
  end

  initial begin
    bit found;
    rst = 1'b1;
    incident_inform = 1'b0;
    incident_b0 = 8'h00; incident_b1 = 8'h00; incident_b2 = 8'h00; incident_b3 = 8'h00;
    tx_ready = 1'b0;
    overflow_clr = 1'b0;
    model_seq = 8'h00;

    // Reset values
    do_reset();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);

    // Single record and its latency
    tx_ready = 1'b1;
    send_strobe(8'h01, 8'h02, 8'h04, 8'h08);
    push_fixed(8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F);
    check("lat_e0_valid", 32'(tx_valid), 32'd0);
    check("lat_e0_count", 32'(fifo_count), 32'd1);
    tick();
    check("lat_e1_valid", 32'(tx_valid), 32'd0);
    tick();
    check("lat_e2_valid", 32'(tx_valid), 32'd1);
    check("lat_e2_hdr", 32'(tx_data), 32'hA5);
    drain(1'b0, 40);

    // Back-pressure with random ready
    do_reset();
    tx_ready = 1'b0;
    send_strobe(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    push_fixed(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC);
    drain(1'b1, 300);
    model_seq = 8'h01;

    // Overflow: ready low, ten strobes on consecutive edges
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_strobe(8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48));
      if (i < 9) push_model(8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48));
    end
    check("ovf_fifo_count", 32'(fifo_count), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop_count", 32'(drop_count), 32'd1);
    send_strobe(8'hEE, 8'hEE, 8'hEE, 8'hEE);
    check("ovf_drop_count2", 32'(drop_count), 32'd2);
    overflow_clr = 1'b1;
    send_strobe(8'hDD, 8'hDD, 8'hDD, 8'hDD);
    overflow_clr = 1'b0;
    check("clr_vs_drop_flag", 32'(overflow), 32'd1);
    check("clr_vs_drop_count", 32'(drop_count), 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("clr_flag", 32'(overflow), 32'd0);
    check("clr_count", 32'(drop_count), 32'd0);
    check("clr_fifo_count", 32'(fifo_count), 32'd8);

    // Push while full in the same cycle as the IDLE pop
    tx_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!tx_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("simul_reached_idle", 32'(found), 32'd1);
    check("simul_pre_count", 32'(fifo_count), 32'd8);
    send_strobe(8'h5A, 8'h5B, 8'h5C, 8'h5D);
    push_model(8'h5A, 8'h5B, 8'h5C, 8'h5D);
    check("simul_fifo_count", 32'(fifo_count), 32'd8);
    check("simul_overflow", 32'(overflow), 32'd0);
    check("simul_drop_count", 32'(drop_count), 32'd0);
    drain(1'b0, 200);

    // Reset mid-frame with three records queued
    tx_ready = 1'b0;
    send_strobe(8'h31, 8'h32, 8'h33, 8'h34);
    push_model(8'h31, 8'h32, 8'h33, 8'h34);
    send_strobe(8'h41, 8'h42, 8'h43, 8'h44);
    send_strobe(8'h51, 8'h52, 8'h53, 8'h54);
    send_strobe(8'h61, 8'h62, 8'h63, 8'h64);
    check("mid_fifo_count", 32'(fifo_count), 32'd3);
    check("mid_valid", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tx_ready = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    model_seq = 8'h00;
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    tx_ready = 1'b1;
    send_strobe(8'h11, 8'h22, 8'h33, 8'h44);
    push_fixed(8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
    drain(1'b0, 40);

    // Sequence wrap over 257 frames
    do_reset();
    tx_ready = 1'b1;
    for (int f = 1; f <= 257; f++) begin
      send_strobe(8'h10, 8'h20, 8'h30, 8'h40);
      if (f == 256)      push_fixed(8'hFF, 8'h10, 8'h20, 8'h30, 8'h40, 8'h9F);
      else if (f == 257) push_fixed(8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0);
      else               push_model(8'h10, 8'h20, 8'h30, 8'h40);
      drain(1'b0, 30);
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
